// File: rtl/nco_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : nco_freq_meter
// Description : Measures the frequency of an unsigned sample stream. Rising
//               midscale crossings (with hysteresis) delimit periods counted
//               in accepted samples; each period is turned into a Q32.32 Hz
//               frequency by a 64-step restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_freq_meter #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BIT_DEPTH   = 8,
    parameter int SAMPLE_RATE = 48000,
    parameter int MAX_PERIOD  = 65535,
    parameter int PERIOD_W    = $clog2(MAX_PERIOD + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_DEPTH-1:0] sample_in,
    input  logic                 sample_valid,
    input  logic [BIT_DEPTH-1:0] hysteresis,
    output logic [63:0]          frequency,
    output logic [PERIOD_W-1:0]  period,
    output logic                 freq_valid,
    output logic                 no_signal,
    output logic                 busy
);

    // Parameter sanity: the sample rate must be a real rate no faster than clk.
    generate
        if (SAMPLE_RATE < 1 || CLK_FREQ < SAMPLE_RATE || MAX_PERIOD < 2) begin : g_bad_params
            $error("nco_freq_meter: invalid SAMPLE_RATE/CLK_FREQ/MAX_PERIOD");
        end
    endgenerate

    localparam logic [BIT_DEPTH:0]  c_HALF      = {2'b01, {(BIT_DEPTH-1){1'b0}}};
    localparam logic [BIT_DEPTH:0]  c_FULL      = {1'b0, {BIT_DEPTH{1'b1}}};
    localparam logic [PERIOD_W-1:0] c_MAX       = PERIOD_W'(MAX_PERIOD);
    localparam logic [PERIOD_W-1:0] c_MAX_M1    = PERIOD_W'(MAX_PERIOD - 1);
    localparam logic [63:0]         c_NUMERATOR = {32'(SAMPLE_RATE), 32'd0};

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_ARMED  = 3'd1;
    localparam logic [2:0] c_ST_LOAD   = 3'd2;
    localparam logic [2:0] c_ST_DIVIDE = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    logic [2:0]          r_state;
    logic                r_level_high;
    logic [PERIOD_W-1:0] r_count;
    logic [PERIOD_W-1:0] r_divisor;
    logic [PERIOD_W-1:0] r_pend_period;
    logic                r_pend_valid;
    logic                r_to_pend;
    logic [PERIOD_W-1:0] r_rem;
    logic [63:0]         r_quo;
    logic [5:0]          r_iter;
    logic [63:0]         r_frequency;
    logic [PERIOD_W-1:0] r_period;
    logic                r_freq_valid;
    logic                r_no_signal;

    logic [BIT_DEPTH:0]  w_hyst_ext;
    logic [BIT_DEPTH:0]  w_sample_ext;
    logic [BIT_DEPTH:0]  w_hi_sum;
    logic [BIT_DEPTH:0]  w_hi_th;
    logic [BIT_DEPTH:0]  w_lo_th;
    logic                w_rise;
    logic                w_fall;
    logic                w_cnt_sat;
    logic                w_timeout;
    logic [PERIOD_W-1:0] w_period_now;
    logic [PERIOD_W:0]   w_rem_shift;
    logic [PERIOD_W:0]   w_div_ext;
    logic                w_sub_ok;
    logic [PERIOD_W-1:0] w_rem_next;
    logic [63:0]         w_quo_next;

    // Thresholds in one extra bit so midscale plus a large dead band cannot wrap.
    always_comb begin
        w_hyst_ext   = {1'b0, hysteresis};
        w_sample_ext = {1'b0, sample_in};
        w_hi_sum     = c_HALF + w_hyst_ext;
        w_hi_th      = (w_hi_sum > c_FULL) ? c_FULL : w_hi_sum;
        w_lo_th      = (w_hyst_ext >= c_HALF) ? '0 : (c_HALF - w_hyst_ext);
        w_rise       = sample_valid && !r_level_high && (w_sample_ext >= w_hi_th);
        w_fall       = sample_valid &&  r_level_high && (w_sample_ext <= w_lo_th);
    end

    // Period of the current crossing includes the crossing sample; a saturated
    // counter reports MAX_PERIOD. Timeout fires only on the step into saturation.
    always_comb begin
        w_cnt_sat    = (r_count == c_MAX);
        w_period_now = w_cnt_sat ? c_MAX : (r_count + PERIOD_W'(1));
        w_timeout    = sample_valid && !w_rise && (r_count == c_MAX_M1);
    end

    // One restoring-division step: shift in the next numerator bit, subtract if it fits.
    always_comb begin
        w_rem_shift = {r_rem, r_quo[63]};
        w_div_ext   = {1'b0, r_divisor};
        w_sub_ok    = (w_rem_shift >= w_div_ext);
        w_rem_next  = w_sub_ok ? PERIOD_W'(w_rem_shift - w_div_ext) : w_rem_shift[PERIOD_W-1:0];
        w_quo_next  = {r_quo[62:0], w_sub_ok};
    end

    // Level tracker with hysteresis: only accepted samples move it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_high <= 1'b0;
        end else if (w_rise) begin
            r_level_high <= 1'b1;
        end else if (w_fall) begin
            r_level_high <= 1'b0;
        end
    end

    // Sample counter runs in every state, restarts on a crossing, saturates at MAX_PERIOD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (sample_valid) begin
            if (w_rise) begin
                r_count <= '0;
            end else if (!w_cnt_sat) begin
                r_count <= r_count + PERIOD_W'(1);
            end
        end
    end

    // Measurement FSM, divider datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_divisor     <= '0;
            r_pend_period <= '0;
            r_pend_valid  <= 1'b0;
            r_to_pend     <= 1'b0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_iter        <= '0;
            r_frequency   <= '0;
            r_period      <= '0;
            r_freq_valid  <= 1'b0;
            r_no_signal   <= 1'b1;
        end else begin
            r_freq_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // First crossing only establishes a period start.
                    if (w_rise) begin
                        r_state <= c_ST_ARMED;
                    end
                end

                c_ST_ARMED: begin
                    if (w_rise) begin
                        r_divisor <= w_period_now;
                        r_state   <= c_ST_LOAD;
                    end else if (w_timeout || r_to_pend) begin
                        r_to_pend <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end
                end

                c_ST_LOAD: begin
                    r_rem  <= '0;
                    r_quo  <= c_NUMERATOR;
                    r_iter <= '0;
                    r_state <= c_ST_DIVIDE;
                    if (w_rise) begin
                        r_pend_period <= w_period_now;
                        r_pend_valid  <= 1'b1;
                    end
                    if (w_timeout) begin
                        r_to_pend <= 1'b1;
                    end
                end

                c_ST_DIVIDE: begin
                    r_rem  <= w_rem_next;
                    r_quo  <= w_quo_next;
                    r_iter <= r_iter + 6'd1;
                    if (r_iter == 6'd63) begin
                        r_state <= c_ST_DONE;
                    end
                    // Single pending slot: the newest crossing overwrites older ones.
                    if (w_rise) begin
                        r_pend_period <= w_period_now;
                        r_pend_valid  <= 1'b1;
                    end
                    if (w_timeout) begin
                        r_to_pend <= 1'b1;
                    end
                end

                c_ST_DONE: begin
                    r_freq_valid <= 1'b1;
                    if (r_to_pend) begin
                        // Signal lost: a running division's result is superseded.
                        r_frequency  <= '0;
                        r_period     <= '0;
                        r_no_signal  <= 1'b1;
                        r_pend_valid <= 1'b0;
                        r_to_pend    <= 1'b0;
                        r_state      <= c_ST_IDLE;
                    end else begin
                        r_frequency <= r_quo;
                        r_period    <= r_divisor;
                        r_no_signal <= 1'b0;
                        if (w_timeout) begin
                            r_to_pend <= 1'b1;
                        end
                        if (w_rise) begin
                            r_divisor    <= w_period_now;
                            r_pend_valid <= 1'b0;
                            r_state      <= c_ST_LOAD;
                        end else if (r_pend_valid) begin
                            r_divisor    <= r_pend_period;
                            r_pend_valid <= 1'b0;
                            r_state      <= c_ST_LOAD;
                        end else begin
                            r_state <= c_ST_ARMED;
                        end
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign frequency  = r_frequency;
    assign period     = r_period;
    assign freq_valid = r_freq_valid;
    assign no_signal  = r_no_signal;
    assign busy       = (r_state == c_ST_LOAD) || (r_state == c_ST_DIVIDE);

endmodule
`default_nettype wire

// File: doc/nco_freq_meter.md
Name: nco_freq_meter

Overview:
- Measures the frequency of an unsigned sample stream, such as the NCO output, and reports it in the same Q32.32 Hz format the NCO accepts.
- Detects rising midscale crossings with hysteresis and counts accepted samples between consecutive crossings.
- Converts each period to frequency with a bit-serial divider.
- Sits downstream of the NCO or a sampled input path for closed-loop tuning checks and self-test.

Parameters:
- CLK_FREQ, 50000000: system clock in Hz; informational, used only for the latency check in the test plan.
- BIT_DEPTH, 8: sample width in bits; samples are unsigned with midscale SAMPLE_HALF = 2^(BIT_DEPTH-1).
- SAMPLE_RATE, 48000: sample rate in Hz; must be < 2^32.
- MAX_PERIOD, 65535: timeout in samples; PERIOD_W = clog2(MAX_PERIOD+1).

Ports:
- clk  input  1  system clock; all logic rises on the posedge.
- rst  input  1  synchronous, active-high reset.
- sample_in  input  BIT_DEPTH  unsigned sample.
- sample_valid  input  1  qualifies sample_in for one clk cycle; it is the only pacing, with no backpressure.
- hysteresis  input  BIT_DEPTH  crossing dead band around SAMPLE_HALF.
- frequency  output  64  measured frequency, Q32.32 Hz, truncated.
- period  output  PERIOD_W  last measured period in samples.
- freq_valid  output  1  one-cycle pulse when frequency, period and no_signal update.
- no_signal  output  1  high while no valid measurement is available.
- busy  output  1  high while the divider is running.

Behaviour:
- Reset values:
  - frequency=0, period=0, freq_valid=0, busy=0, no_signal=1.
  - Level state = LOW, counter=0, FSM = IDLE, pending cleared.
  - Reset in any state aborts any division; no freq_valid is issued.
- Thresholds, computed in BIT_DEPTH+1 bits and re-evaluated on every accepted sample:
  - hi_th = min(SAMPLE_HALF+hysteresis, 2^BIT_DEPTH-1).
  - lo_th = max(SAMPLE_HALF-hysteresis, 0).
- Level state, updated only when sample_valid=1:
  - LOW to HIGH when sample_in >= hi_th. This transition is a rising crossing.
  - HIGH to LOW when sample_in <= lo_th.
  - Otherwise the level holds.
- Sample counter, advanced only on accepted samples:
  - Increments by 1 on each accepted sample.
  - On a crossing, the value including the crossing sample is the period, and the counter restarts at 0.
  - The counter keeps running in every FSM state.
- FSM states:
  - IDLE: the first crossing only arms the meter (go to ARMED); no output.
  - ARMED: a crossing latches the period and goes to DIVIDE.
  - DIVIDE: restoring divide of numerator SAMPLE_RATE<<32 (64-bit) by the period, 1 quotient bit per clk, 64 iterations, busy=1. On completion go to DONE.
  - DONE: for one cycle, register frequency=quotient and period, set no_signal=0, pulse freq_valid. Then go to ARMED, or start DIVIDE on the next cycle if a period is pending.
- Latency:
  - The crossing sample is accepted at edge N.
  - frequency, period and freq_valid update at edge N+66, one divider load cycle plus 64 iterations plus DONE.
- Crossing during DIVIDE or DONE: the new period is stored in a single pending slot, and a newer crossing overwrites it (newest wins). No crossing is lost to the counter.
- Timeout:
  - Applies in ARMED or DIVIDE when the counter reaches MAX_PERIOD with no crossing.
  - A running division completes normally first.
  - Then in one DONE cycle: frequency=0, period=0, no_signal=1, freq_valid pulses. Pending is cleared and the FSM returns to IDLE.
  - The timeout fires once; no repeat pulses while the signal stays absent.
  - Timeout also applies in IDLE, but it only saturates the counter and produces no pulse.
- Simultaneous timeout and crossing on the same sample: the crossing wins and the counter restarts.
- freq_valid is never high for two consecutive cycles.
- Outputs hold their values between pulses.

Test Plan:
- SAMPLE_RATE=48000, BIT_DEPTH=8, hysteresis=16, square wave 0x00/0xFF with a 48-sample period, sample_valid every 4 clk. Required: first freq_valid after the second crossing; period=48; frequency=0x000003E8_00000000; no_signal=0; pulse 66 clk after the crossing sample.
- Period of 7 samples, sample_valid every clk. Required: frequency=0x00001AC9_24924924, period=7, with back-to-back measurements. Crossings during DIVIDE are serviced from pending with the newest value, and each freq_valid pulse is 1 cycle wide.
- Sine-like ramp with ±10 LSB noise around 0x80, hysteresis=16. Required: no extra crossings, and period equals the true period. With hysteresis=0, a noisy midscale dwell produces spurious short periods.
- Measure 1000 Hz, then hold sample_in=0x80, MAX_PERIOD=100. Required: exactly one pulse with frequency=0, period=0, no_signal=1. A following valid tone produces its first output only after two crossings.
- Assert rst mid-DIVIDE. Required: no freq_valid pulse; all outputs at reset values the next cycle; measurement restarts from IDLE. Additionally, hysteresis=0xFF must give hi_th=0xFF and lo_th=0x00 with no overflow, and crossings occur only on full-scale samples.
